// File: rtl/audio_frame_serializer.sv
// Audio frame serializer: derives bit clock, word select and frame request from clk,
// and shifts one captured mono word out MSB-first, left-justified on both channels.
module audio_frame_serializer #(
    parameter int BCLK_HALF = 8,
    parameter int sim       = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sample,
    input  logic        play,
    output logic        new_frame,
    output logic        sclk,
    output logic        lrclk,
    output logic        sdata
);

    localparam int H     = (sim != 0) ? 2 : BCLK_HALF;
    localparam int DIV_W = (H > 1) ? $clog2(H) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(H - 1);

    logic [DIV_W-1:0]    r_div_cnt;
    logic                r_sclk;
    logic [4:0]          r_bit_cnt;
    logic                r_lrclk;
    logic                r_sdata;
    logic                r_new_frame;
    logic signed [15:0]  r_hold;
    logic signed [15:0]  r_tx_word;

    logic                w_tick;
    logic                w_fall;
    logic [4:0]          w_nb;

    function automatic logic signed [15:0] capture_word(input logic signed [15:0] s,
                                                        input logic p);
        capture_word = p ? s : 16'sh0000;
    endfunction

    assign w_tick = (r_div_cnt == DIV_LAST);
    assign w_fall = w_tick && r_sclk;
    assign w_nb   = r_bit_cnt + 5'd1;

    // Bit-clock divider
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_div_cnt <= '0;
            r_sclk    <= 1'b0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            if (w_tick) begin
                r_sclk <= ~r_sclk;
            end
        end
    end

    // Frame sequencing: every output advances only on sclk falling events
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bit_cnt   <= 5'd31;
            r_lrclk     <= 1'b1;
            r_sdata     <= 1'b0;
            r_new_frame <= 1'b0;
            r_hold      <= '0;
            r_tx_word   <= '0;
        end else if (w_fall) begin
            r_bit_cnt   <= w_nb;
            r_lrclk     <= w_nb[4];
            r_new_frame <= (w_nb[4:3] == 2'b00);
            if (w_nb == 5'd0) begin
                r_tx_word <= r_hold;
                r_sdata   <= r_hold[15];
            end else begin
                // 15 - nb[3:0] is the bitwise complement of a 4-bit value
                r_sdata   <= r_tx_word[~w_nb[3:0]];
            end
            if (w_nb == 5'd24) begin
                r_hold <= capture_word($signed(sample), play);
            end
        end
    end

    assign sclk      = r_sclk;
    assign lrclk     = r_lrclk;
    assign sdata     = r_sdata;
    assign new_frame = r_new_frame;

endmodule

// File: tb/tb_audio_frame_serializer.sv
// Bench for audio_frame_serializer: three instances (H=2, sim-forced H=2, H=3) checked
// every cycle against a time-based frame model, plus literal frame/timing expectations.
module tb_audio_frame_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sample;
    logic        play;
    logic [2:0]  w_sclk, w_lr, w_sd, w_nf;

    always #5 clk = ~clk;

    audio_frame_serializer #(.BCLK_HALF(2), .sim(0)) dut_a (
        .clk(clk), .reset(reset), .sample(sample), .play(play),
        .new_frame(w_nf[0]), .sclk(w_sclk[0]), .lrclk(w_lr[0]), .sdata(w_sd[0]));
    audio_frame_serializer #(.BCLK_HALF(8), .sim(1)) dut_b (
        .clk(clk), .reset(reset), .sample(sample), .play(play),
        .new_frame(w_nf[1]), .sclk(w_sclk[1]), .lrclk(w_lr[1]), .sdata(w_sd[1]));
    audio_frame_serializer #(.BCLK_HALF(3), .sim(0)) dut_c (
        .clk(clk), .reset(reset), .sample(sample), .play(play),
        .new_frame(w_nf[2]), .sclk(w_sclk[2]), .lrclk(w_lr[2]), .sdata(w_sd[2]));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s dut%0d actual=%h required=%h", name, d, act, req);
    endtask

    // Model: edges since reset release, falls at every 2H edges, word pipeline per frame
    int          HV[3] = '{2, 2, 3};
    int          mk[3];
    int          mnb[3];
    logic [15:0] cur[3];
    logic [15:0] nxt[3];
    bit          mvalid = 1'b0;

    always @(posedge clk) begin
        int m;
        for (int d = 0; d < 3; d++) begin
            if (!reset) begin
                mk[d] = 0; mnb[d] = -1; cur[d] = 16'h0; nxt[d] = 16'h0;
            end else begin
                mk[d]++;
                if (mk[d] % (2 * HV[d]) == 0) begin
                    m = mk[d] / (2 * HV[d]);
                    mnb[d] = (m - 1) % 32;
                    if (mnb[d] == 0)  cur[d] = nxt[d];
                    if (mnb[d] == 24) nxt[d] = play ? sample : 16'h0;
                end
            end
        end
        if (!reset) mvalid = 1'b1;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            for (int d = 0; d < 3; d++) begin
                logic e_lr, e_sd, e_nf;
                if (mnb[d] < 0) begin
                    e_lr = 1'b1; e_sd = 1'b0; e_nf = 1'b0;
                end else begin
                    e_lr = (mnb[d] >= 16);
                    e_nf = (mnb[d] < 8);
                    e_sd = cur[d][15 - (mnb[d] % 16)];
                end
                chk("sclk",      d, 32'(w_sclk[d]), 32'((mk[d] / HV[d]) % 2));
                chk("lrclk",     d, 32'(w_lr[d]),   32'(e_lr));
                chk("sdata",     d, 32'(w_sd[d]),   32'(e_sd));
                chk("new_frame", d, 32'(w_nf[d]),   32'(e_nf));
            end
        end
    end

    // Per-frame capture of dut_a serial data and new_frame duty, keyed by edges since release
    logic [31:0] frm[16];
    int          nf_cnt;

    always @(negedge clk) begin
        if (mvalid) begin
            if (mk[0] == 0) begin
                for (int f = 0; f < 16; f++) frm[f] = 32'h0;
                nf_cnt = 0;
            end else begin
                if (mk[0] % 4 == 0) begin
                    int f;
                    f = (mk[0] / 4 - 1) / 32;
                    if (f < 16) frm[f] = {frm[f][30:0], w_sd[0]};
                end
                if (mk[0] >= 4 && mk[0] <= 131) nf_cnt += int'(w_nf[0]);
            end
        end
    end

    task automatic wait_k(input int t);
        int guard = 0;
        while (mk[0] < t) begin
            @(negedge clk);
            guard++;
            if (guard > 5000) begin
                chk("wait_timeout", 0, 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk({tag, "_sclk"},  d, 32'(w_sclk[d]), 32'd0);
            chk({tag, "_lrclk"}, d, 32'(w_lr[d]),   32'd1);
            chk({tag, "_sdata"}, d, 32'(w_sd[d]),   32'd0);
            chk({tag, "_nf"},    d, 32'(w_nf[d]),   32'd0);
        end
    endtask

    initial begin
        reset = 1'b0; sample = 16'h0; play = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b1; sample = 16'hA5C3; play = 1'b1;

        wait_k(3);  chk("nf_edge3", 0, 32'(w_nf[0]), 32'd0);
        wait_k(4);  chk("nf_edge4", 0, 32'(w_nf[0]), 32'd1);
        // frame 0 captures A5C3 at edge 100; mute across frame 1 capture at 228
        wait_k(110); sample = 16'hFFFF; play = 1'b0;
        wait_k(140); chk("nf_duty", 0, 32'(nf_cnt), 32'd32);
        wait_k(240); sample = 16'h1234; play = 1'b1;
        wait_k(356); sample = 16'h8001;
        wait_k(641);
        chk("frame0_zero",  0, frm[0], 32'h0000_0000);
        chk("frame1_data",  0, frm[1], 32'hA5C3_A5C3);
        chk("frame2_mute",  0, frm[2], 32'h0000_0000);
        chk("frame3_1234",  0, frm[3], 32'h1234_1234);
        chk("frame4_8001",  0, frm[4], 32'h8001_8001);

        for (int i = 0; i < 1500; i++) begin
            sample = 16'($urandom);
            play   = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end

        // mid-frame reset once dut_a's bit counter has just reached 10
        begin
            int guard = 0;
            while (mk[0] % 128 != 44 && guard < 200) begin
                @(negedge clk); guard++;
            end
            chk("find_bit10", 0, 32'(mk[0] % 128), 32'd44);
        end
        chk("pre_rst_lrclk", 0, 32'(w_lr[0]), 32'd0);
        reset = 1'b0; sample = 16'h7FFF; play = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        reset = 1'b1;
        wait_k(3);  chk("nf2_edge3", 0, 32'(w_nf[0]), 32'd0);
        wait_k(4);  chk("nf2_edge4", 0, 32'(w_nf[0]), 32'd1);
        wait_k(260);
        chk("rst_frame0_zero", 0, frm[0], 32'h0000_0000);
        chk("rst_frame1_data", 0, frm[1], 32'h7FFF_7FFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/audio_frame_serializer.md
Name: audio_frame_serializer

Overview:
- Downstream consumer of the music player's 16-bit `sample` output, and the source of its `NewFrame` input.
- Generates audio frame timing from `clk`: bit clock, word-select and frame-request pulse.
- Latches one mono sample per frame and shifts it out MSB-first, left-justified, on both channels (identical L/R).
- Replaces the external codec frame source, so the player/codec boundary is fully owned by this block.

Parameters:
- BCLK_HALF, 8, number of clk cycles per half period of `sclk`; legal range ≥1.
- sim, 0, when 1 the effective BCLK_HALF is forced to 2 for fast simulation.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset; all state clears on a rising clk edge while reset=0.
- sample  input  16  audio word from the music player (two's complement).
- play  input  1  player play flag; when 0, the captured word is forced to 0.
- new_frame  output  1  frame request to the music player's NewFrame input (registered level).
- sclk  output  1  serial bit clock.
- lrclk  output  1  word select: 0 = left, 1 = right.
- sdata  output  1  serial data; changes only on sclk falling events.

Behaviour:
- Notation: H = effective BCLK_HALF.
- Reset state:
  - div_cnt=0, sclk=0, bit_cnt=31.
  - lrclk=1, sdata=0, new_frame=0.
  - hold=0, tx_word=0.
  - Reset has priority over every other event. Mid-frame assertion returns all state to these values on the next edge; no partial word completes.
- Divider:
  - div_cnt counts 0..H-1 and wraps.
  - At div_cnt==H-1, sclk toggles. sclk period = 2H clk.
- Fall event:
  - Defined as the cycle with div_cnt==H-1 and sclk==1.
  - All updates below happen only on fall events. Let nb = (bit_cnt+1) mod 32; bit_cnt <= nb.
- Frame = 32 bit slots = 64H clk cycles.
- Outputs, all registered on fall:
  - lrclk <= nb[4].
  - new_frame <= (nb < 8), i.e. high for 8 bit slots = 16H clk per frame. This is long enough for the player's synchronizer.
  - If nb==0: tx_word <= hold and sdata <= hold[15].
  - Otherwise: sdata <= tx_word[15 - nb[3:0]].
  - The right channel (nb 16..31) retransmits the same tx_word MSB-first.
- Capture:
  - On the fall with nb==24: hold <= play ? sample : 16'h0000.
  - sample and play are sampled only at this instant; changes at any other time are ignored.
  - Latency: a word captured in frame N is transmitted throughout frame N+1, starting at its nb==0 fall.
- First frame after reset release:
  - The first fall occurs on the 4th rising edge after release when H=2; generally at 2H edges.
  - That fall produces nb=0 and loads hold=0, so the first frame transmits zeros.
- No handshake back-pressure: the player must supply a valid sample before the capture point. An unchanged sample is simply re-sent.
- play toggling mid-frame affects only the next capture.
- bit_cnt wraps 31→0 without gaps; there is no idle state.

Test Plan:
- Reset: hold reset=0 for 3 cycles (H=2) → sclk=0, lrclk=1, sdata=0, new_frame=0. After release → sclk period 4 clk; new_frame high for 32 clk out of every 128; first frame sdata all 0.
- Data: sample=16'hA5C3, play=1 constant → in the following frame, sdata on the 16 left slots (lrclk=0) = 1010_0101_1100_0011 MSB-first, and the identical 16 bits on lrclk=1.
- Mute: sample=16'hFFFF, play=0 across the capture point → the entire next frame has sdata=0 on both channels.
- Capture timing: sample=16'h1234 at the nb==24 fall, then changed to 16'h8001 one clk later → next frame transmits 16'h1234; 16'h8001 appears one frame after that.
- Mid-frame reset: assert reset at bit_cnt=10 → reset values on the next edge. After release, new_frame rises on the 4th edge and the first frame transmits zeros.
- sim=1 with BCLK_HALF=8 → sclk period 4 clk, frame 128 clk, same data behaviour as the H=2 runs.
